memory_cycle: RTL and testbench
===============================

# memory_cycle

Memory stage of the 5-stage RISC-V pipeline. Consumes the EX/MEM pipeline register outputs and performs word loads and stores over a valid/ready data-memory bus. It stalls the upstream stages while a bus transaction is outstanding and registers the MEM/WB outputs that feed write-back.

## Interface
Parameters:
- BUS_TIMEOUT, 16: maximum cycles spent in REQ plus WAIT_RESP before the access is aborted; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- RegWriteM, MemWriteM  in  1 each  EX/MEM controls.
- ResultSrcM  in  2  result select: 00 = ALU, 01 = memory read, 10 = PC+4.
- RD_M  in  5  destination register.
- PCPlus4M, WriteDataM, ALU_ResultM  in  32 each  EX/MEM data; ALU_ResultM is the byte address for loads and stores.
- dmem_valid  out  1  request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  store data.
- dmem_ready  in  1  request accepted this cycle when it coincides with dmem_valid.
- dmem_rvalid, dmem_rdata  in  1, 32  load response.
- StallM  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- MisalignM, BusErrM  out  1 each  exception pulses.
- RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW  out  1/2/5/32/32/32  MEM/WB register.

## Operation
- access = MemWriteM | (ResultSrcM == 01). A load is access & !MemWriteM.
- A misaligned access (access & ALU_ResultM[1:0] != 0) issues no bus request.
  - MisalignM = 1 in that cycle and there is no stall.
  - The MEM/WB register loads with RegWriteW forced to 0.
- FSM states: IDLE, REQ, WAIT_RESP.
- IDLE: when there is an aligned access, dmem_valid = 1, driven combinationally from the EX/MEM inputs.
  - dmem_ready & (store | dmem_rvalid): the access completes this cycle and the FSM stays in IDLE.
  - dmem_ready & load & !dmem_rvalid: go to WAIT_RESP.
  - !dmem_ready: go to REQ.
- REQ: dmem_valid held at 1 and addr/we/wdata held stable, since the inputs are frozen by StallM. Same completion and transition rules as IDLE.
- WAIT_RESP: dmem_valid = 0. dmem_rvalid completes the load and returns the FSM to IDLE.
- dmem_rvalid is ignored in IDLE and REQ unless a load is accepted in that same cycle.
- Timeout: a counter clears on entering REQ, increments each cycle spent in REQ/WAIT_RESP, and saturates at BUS_TIMEOUT.
  - When it equals BUS_TIMEOUT without completion, BusErrM pulses for 1 cycle and the FSM returns to IDLE.
  - The instruction completes with RegWriteW = 0.
- StallM = aligned access & !complete & !timeout, combinational in the same cycle.
- MEM/WB register behaviour:
  - Stalled cycle: load a bubble (RegWriteW = 0, ResultSrcW = 00, RD_W = 0, other fields 0).
  - Otherwise: load the M inputs.
  - ReadDataW = dmem_rdata captured on load completion, and 0 for any other instruction.
- dmem_addr = {ALU_ResultM[31:2], 2'b00}. dmem_we = MemWriteM. dmem_wdata = WriteDataM. All three are 0 when dmem_valid = 0.

## Timing
- Reset (rst low, asynchronous): state = IDLE, counter = 0, all MEM/WB outputs = 0.
  - dmem_valid, StallM, MisalignM and BusErrM are 0 while rst is low.
  - A reset mid-transaction abandons it. No response is consumed afterward.
- Zero-wait memory (ready and rvalid in the same cycle as valid): no stall. W outputs update at the next edge, giving 1-cycle latency like every pipeline stage.
- N-cycle ready delay: StallM is high for N cycles. W updates on the edge after the ready cycle.
- A load whose rvalid arrives K cycles after acceptance stalls for K additional cycles.
- Timeout fires on cycle BUS_TIMEOUT after leaving IDLE, with BusErrM and StallM = 0 in that cycle.
- Back-to-back accesses: the next request may assert in the cycle after completion, with no idle gap.

## Structure
- Shared package riscv_pkg holds:
  - ResultSrc encodings RES_ALU / RES_MEM / RES_PC4;
  - the FSM state enum;
  - an exception-cause constants slot for MisalignM and BusErrM.
- One sub-module, lsu_fsm, contains the state register, timeout counter, dmem handshake and StallM. The top level holds the MEM/WB register and the misalignment check.

## Test plan
- ALU op, ALU_ResultM = 0x1234, RegWriteM = 1, RD_M = 5 → next edge RegWriteW = 1, RD_W = 5, ALU_ResultW = 0x1234, no dmem_valid.
- Store to 0x100 with data 0xDEADBEEF, ready held low 3 cycles → StallM high 3 cycles, address and data stable throughout, W bubbles, then RegWriteW = 0 and the pipeline advances.
- Load from 0x200 with ready on cycle 0 and rvalid on cycle 2 with 0xCAFEF00D → StallM high 2 cycles, then ReadDataW = 0xCAFEF00D, ResultSrcW = 01.
- Load from 0x202 → MisalignM pulse, no dmem_valid, RegWriteW = 0, no stall.
- Load with rvalid never arriving, BUS_TIMEOUT = 16 → BusErrM pulse on cycle 16, StallM drops, RegWriteW = 0.
- rst low while in WAIT_RESP → dmem_valid = 0 and W outputs 0 immediately. A late rvalid after release is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline: result-select encodings,
// load/store unit FSM states and exception cause codes.
package riscv_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RESP
    } lsu_state_e;

    // mcause codes reported for MisalignM / BusErrM
    typedef enum logic [3:0] {
        EXC_LOAD_MISALIGN  = 4'd4,
        EXC_LOAD_ACCESS    = 4'd5,
        EXC_STORE_MISALIGN = 4'd6,
        EXC_STORE_ACCESS   = 4'd7
    } exc_cause_e;

endpackage

// File: rtl/lsu_fsm.sv
// Data-memory handshake for the MEM stage: request/response FSM, bus timeout
// counter and the upstream stall.
module lsu_fsm #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_valid_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ready_i,
    input  logic        dmem_rvalid_i,
    output logic        stall_o,
    output logic        complete_o,
    output logic        timeout_o
);
    import riscv_pkg::*;

    localparam int             CW      = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(BUS_TIMEOUT);

    lsu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          issue, complete, timeout, accept_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LSU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign accept_done = dmem_ready_i & (we_i | dmem_rvalid_i);

    // cnt_q holds the index of the current cycle since the access left IDLE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        issue    = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                cnt_d = CW'(1);
                if (req_i) begin
                    issue = 1'b1;
                    if (accept_done)       complete = 1'b1;
                    else if (dmem_ready_i) state_d  = LSU_WAIT_RESP;
                    else                   state_d  = LSU_REQ;
                end
            end
            LSU_REQ: begin
                issue = 1'b1;
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (accept_done) begin
                    complete = 1'b1;
                    state_d  = LSU_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    timeout = 1'b1;
                    state_d = LSU_IDLE;
                end else if (dmem_ready_i) begin
                    state_d = LSU_WAIT_RESP;
                end
            end
            LSU_WAIT_RESP: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (dmem_rvalid_i) begin
                    complete = 1'b1;
                    state_d  = LSU_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    timeout = 1'b1;
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    assign dmem_valid_o = rst & issue;
    assign dmem_we_o    = dmem_valid_o & we_i;
    assign dmem_addr_o  = dmem_valid_o ? {addr_i[31:2], 2'b00} : 32'd0;
    assign dmem_wdata_o = dmem_valid_o ? wdata_i : 32'd0;
    assign stall_o      = rst & req_i & ~complete & ~timeout;
    assign complete_o   = rst & complete;
    assign timeout_o    = rst & timeout;

endmodule

// File: rtl/memory_cycle.sv
// RISC-V MEM stage: misalignment check, data-memory access through lsu_fsm
// and the MEM/WB pipeline register.
module memory_cycle #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        dmem_valid,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW
);
    import riscv_pkg::*;

    logic access, load, misalign, req, complete, timeout;

    logic        regwrite_q, regwrite_d;
    logic [1:0]  resultsrc_q, resultsrc_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rdata_q, rdata_d;

    assign access   = MemWriteM | (ResultSrcM == RES_MEM);
    assign load     = access & ~MemWriteM;
    assign misalign = access & (ALU_ResultM[1:0] != 2'b00);
    assign req      = access & ~misalign;

    lsu_fsm #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_lsu (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .we_i         (MemWriteM),
        .addr_i       (ALU_ResultM),
        .wdata_i      (WriteDataM),
        .dmem_valid_o (dmem_valid),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .dmem_ready_i (dmem_ready),
        .dmem_rvalid_i(dmem_rvalid),
        .stall_o      (StallM),
        .complete_o   (complete),
        .timeout_o    (timeout)
    );

    // A stalled cycle sends a bubble to WB; faulted accesses retire without writing back
    always_comb begin
        regwrite_d  = 1'b0;
        resultsrc_d = RES_ALU;
        rd_d        = 5'd0;
        pc4_d       = 32'd0;
        alu_d       = 32'd0;
        rdata_d     = 32'd0;
        if (!StallM) begin
            regwrite_d  = RegWriteM & ~misalign & ~timeout;
            resultsrc_d = ResultSrcM;
            rd_d        = RD_M;
            pc4_d       = PCPlus4M;
            alu_d       = ALU_ResultM;
            rdata_d     = (complete & load) ? dmem_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 2'b00;
            rd_q        <= 5'd0;
            pc4_q       <= 32'd0;
            alu_q       <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            rd_q        <= rd_d;
            pc4_q       <= pc4_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
        end
    end

    assign MisalignM   = rst & misalign;
    assign BusErrM     = timeout;
    assign RegWriteW   = regwrite_q;
    assign ResultSrcW  = resultsrc_q;
    assign RD_W        = rd_q;
    assign PCPlus4W    = pc4_q;
    assign ALU_ResultW = alu_q;
    assign ReadDataW   = rdata_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: directed scenarios plus randomized
// transactions scored against a transaction-level timing model.
module tb_memory_cycle;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        dmem_valid, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        StallM, MisalignM, BusErrM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

    int checks = 0;
    int errors = 0;

    memory_cycle #(.BUS_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .dmem_valid(dmem_valid), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
    );

    always #5 clk = ~clk;

    // One instruction through MEM. The memory answers with ready d_ready cycles
    // after the request first appears and, for loads, rvalid d_rv cycles after that.
    task automatic run_txn(input string name, input logic rw, input logic mw,
                           input logic [1:0] rs, input logic [4:0] rd,
                           input logic [31:0] pc4, input logic [31:0] wd,
                           input logic [31:0] alu, input int d_ready, input int d_rv,
                           input logic [31:0] rdata);
        logic access, load, mis, tmo, exp_valid;
        int c, e;
        access = mw | (rs == 2'b01);
        load   = access & !mw;
        mis    = access & (alu[1:0] != 2'b00);
        if (!access || mis) begin
            c = 0; tmo = 1'b0; e = 0;
        end else begin
            c   = d_ready + (load ? d_rv : 0);
            tmo = (c > TO);
            e   = tmo ? TO : c;
        end
        for (int k = 0; k <= e; k++) begin
            RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
            PCPlus4M = pc4; WriteDataM = wd; ALU_ResultM = alu;
            if (access && !mis) begin
                dmem_ready  = (k == d_ready);
                dmem_rvalid = load && (k == d_ready + d_rv);
                dmem_rdata  = dmem_rvalid ? rdata : $urandom;
            end else begin
                dmem_ready  = 1'($urandom);
                dmem_rvalid = 1'($urandom);
                dmem_rdata  = $urandom;
            end
            @(negedge clk);
            exp_valid = access && !mis && (k <= d_ready);
            checks++;
            if (StallM !== (k < e))
                $display("FAIL %s stall k=%0d got %b exp %b", name, k, StallM, (k < e));
            if (StallM !== (k < e)) errors++;
            checks++;
            if (dmem_valid !== exp_valid) begin
                errors++;
                $display("FAIL %s valid k=%0d got %b exp %b", name, k, dmem_valid, exp_valid);
            end
            checks++;
            if (exp_valid) begin
                if (dmem_addr !== {alu[31:2], 2'b00} || dmem_we !== mw || dmem_wdata !== wd) begin
                    errors++;
                    $display("FAIL %s bus k=%0d got addr %h we %b wdata %h exp %h %b %h",
                             name, k, dmem_addr, dmem_we, dmem_wdata, {alu[31:2], 2'b00}, mw, wd);
                end
            end else if (dmem_addr !== 32'd0 || dmem_we !== 1'b0 || dmem_wdata !== 32'd0) begin
                errors++;
                $display("FAIL %s bus_idle k=%0d got addr %h we %b wdata %h exp zeros",
                         name, k, dmem_addr, dmem_we, dmem_wdata);
            end
            checks++;
            if (MisalignM !== mis) begin
                errors++;
                $display("FAIL %s misalign k=%0d got %b exp %b", name, k, MisalignM, mis);
            end
            checks++;
            if (BusErrM !== (tmo && k == e)) begin
                errors++;
                $display("FAIL %s buserr k=%0d got %b exp %b", name, k, BusErrM, (tmo && k == e));
            end
            @(posedge clk);
            #1;
            checks++;
            if (k < e) begin
                if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== 104'd0) begin
                    errors++;
                    $display("FAIL %s bubble k=%0d got rw %b rd %0d alu %h rdata %h exp zeros",
                             name, k, RegWriteW, RD_W, ALU_ResultW, ReadDataW);
                end
            end else begin
                if (RegWriteW !== (rw & !mis & !tmo)) begin
                    errors++;
                    $display("FAIL %s regwrite_w got %b exp %b", name, RegWriteW, (rw & !mis & !tmo));
                end
                checks++;
                if (ReadDataW !== ((load && !mis && !tmo) ? rdata : 32'd0)) begin
                    errors++;
                    $display("FAIL %s readdata_w got %h exp %h", name, ReadDataW,
                             ((load && !mis && !tmo) ? rdata : 32'd0));
                end
                checks++;
                if ({ResultSrcW, RD_W, PCPlus4W, ALU_ResultW} !== {rs, rd, pc4, alu}) begin
                    errors++;
                    $display("FAIL %s wfields got rs %b rd %0d pc4 %h alu %h exp %b %0d %h %h",
                             name, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, rs, rd, pc4, alu);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; RD_M = 5'd3;
        PCPlus4M = 32'h44; WriteDataM = 32'h0; ALU_ResultM = 32'h200;
        dmem_ready = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        #2;
        checks++;
        if (dmem_valid !== 1'b0 || StallM !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got valid %b stall %b exp 0 0", dmem_valid, StallM);
        end
        ALU_ResultM = 32'h202;
        #1;
        checks++;
        if (MisalignM !== 1'b0 || BusErrM !== 1'b0) begin
            errors++;
            $display("FAIL reset_exc got misalign %b buserr %b exp 0 0", MisalignM, BusErrM);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== 104'd0) begin
            errors++;
            $display("FAIL reset_w got rw %b rd %0d alu %h exp zeros", RegWriteW, RD_W, ALU_ResultW);
        end
        ResultSrcM = 2'b00;
        rst = 1'b1;
    endtask

    task automatic test_reset_mid();
        run_txn("pre_reset_alu", 1'b1, 1'b0, 2'b10, 5'd9, 32'h1004, 32'h0, 32'h5555_0000, 0, 0, 32'h0);
        rst = 1'b0;
        #1;
        checks++;
        if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== 104'd0) begin
            errors++;
            $display("FAIL reset_async_w got rw %b rd %0d pc4 %h exp zeros", RegWriteW, RD_W, PCPlus4W);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        // load 0x300 accepted in its first cycle, response withheld so the FSM waits
        RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; RD_M = 5'd12;
        PCPlus4M = 32'h2000; ALU_ResultM = 32'h300; WriteDataM = 32'h0;
        dmem_ready = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        @(posedge clk);
        #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (StallM !== 1'b1 || dmem_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_resp got stall %b valid %b exp 1 0", StallM, dmem_valid);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (dmem_valid !== 1'b0 || StallM !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ctrl got valid %b stall %b exp 0 0", dmem_valid, StallM);
        end
        checks++;
        if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== 104'd0) begin
            errors++;
            $display("FAIL reset_mid_w got rw %b rd %0d exp zeros", RegWriteW, RD_W);
        end
        RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b00; RD_M = 5'd13;
        PCPlus4M = 32'h2004; ALU_ResultM = 32'h0000_0abc;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (StallM !== 1'b0 || dmem_valid !== 1'b0) begin
            errors++;
            $display("FAIL late_rvalid_ctrl got stall %b valid %b exp 0 0", StallM, dmem_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ReadDataW !== 32'd0 || RegWriteW !== 1'b1 || RD_W !== 5'd13) begin
            errors++;
            $display("FAIL late_rvalid_w got rdata %h rw %b rd %0d exp 0 1 13", ReadDataW, RegWriteW, RD_W);
        end
        run_txn("post_reset_load", 1'b1, 1'b0, 2'b01, 5'd14, 32'h2008, 32'h0, 32'h304, 0, 0, 32'h600D_F00D);
    endtask

    task automatic test_directed();
        run_txn("alu", 1'b1, 1'b0, 2'b00, 5'd5, 32'h104, 32'h0, 32'h1234, 0, 0, 32'h0);
        run_txn("store_wait", 1'b0, 1'b1, 2'b00, 5'd0, 32'h108, 32'hDEADBEEF, 32'h100, 3, 0, 32'h0);
        run_txn("load_rv2", 1'b1, 1'b0, 2'b01, 5'd7, 32'h10c, 32'h0, 32'h200, 0, 2, 32'hCAFEF00D);
        run_txn("misalign", 1'b1, 1'b0, 2'b01, 5'd8, 32'h110, 32'h0, 32'h202, 0, 0, 32'h0);
        run_txn("timeout_load", 1'b1, 1'b0, 2'b01, 5'd9, 32'h114, 32'h0, 32'h400, 0, 1000, 32'h1);
        run_txn("timeout_req", 1'b0, 1'b1, 2'b00, 5'd0, 32'h118, 32'h1357, 32'h404, 1000, 0, 32'h0);
        run_txn("edge_rv16", 1'b1, 1'b0, 2'b01, 5'd10, 32'h11c, 32'h0, 32'h408, 0, TO, 32'h0F0F_1234);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_st0", 1'b0, 1'b1, 2'b00, 5'd0, 32'h200, 32'hA5A5_0001, 32'h500, 0, 0, 32'h0);
        run_txn("b2b_ld1", 1'b1, 1'b0, 2'b01, 5'd2, 32'h204, 32'h0, 32'h504, 0, 0, 32'h7777_8888);
        run_txn("b2b_st2", 1'b0, 1'b1, 2'b00, 5'd0, 32'h208, 32'hA5A5_0002, 32'h508, 0, 0, 32'h0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic        mw;
            logic [1:0]  rs;
            logic [31:0] alu;
            int          dr, dv;
            mw  = ($urandom_range(0, 3) == 0);
            rs  = 2'($urandom_range(0, 2));
            alu = $urandom;
            if ($urandom_range(0, 4) != 0) alu[1:0] = 2'b00;
            dr = ($urandom_range(0, 9) == 0) ? 18 : $urandom_range(0, 4);
            dv = ($urandom_range(0, 9) == 0) ? 17 : $urandom_range(0, 4);
            run_txn("random", 1'($urandom), mw, rs, 5'($urandom), $urandom, $urandom, alu, dr, dv, $urandom);
        end
    endtask

    initial begin
        RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00; RD_M = 5'd0;
        PCPlus4M = 32'd0; WriteDataM = 32'd0; ALU_ResultM = 32'd0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
